// File: rtl/edsac_pkg.sv
// Shared constants and types for the serial accumulator slice.
package edsac_pkg;

    // Pulses per minor cycle: 17 data bits plus 1 pad bit, LSB first.
    localparam int WORD_BITS = 18;

    // Width of the bit-position counter (must hold WORD_BITS-1).
    localparam int POS_BITS = 5;

    // Accumulator mode for one whole minor cycle.
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ADD   = 2'd1,
        CLEAR = 2'd2
    } acc_mode_e;

endpackage

// File: rtl/minor_cycle_timer.sv
// Free-running bit-position counter that frames the minor cycle.
module minor_cycle_timer #(
    parameter int WORD_BITS = edsac_pkg::WORD_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [edsac_pkg::POS_BITS-1:0] bit_pos,
    output logic                          minor_start,
    output logic                          last_bit
);
    import edsac_pkg::*;

    localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(WORD_BITS - 1);

    logic [POS_BITS-1:0] pos_q;
    logic [POS_BITS-1:0] pos_d;

    // Count 0..WORD_BITS-1 and wrap back to 0.
    always_comb begin
        pos_d = pos_q + 1'b1;
        if (pos_q == LAST_POS) begin
            pos_d = '0;
        end
    end

    // Position register; reset restarts framing at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign bit_pos     = pos_q;
    assign minor_start = (pos_q == '0);
    assign last_bit    = (pos_q == LAST_POS);

endmodule

// File: rtl/serial_accumulator.sv
// Serial accumulator tank: a recirculating right-shift register whose
// write-back bit is chosen per minor cycle (hold, add result, or clear).
// Mode changes happen only at the minor-cycle boundary; requests are
// latched in a one-deep pending slot in between.
module serial_accumulator #(
    parameter int WORD_BITS = edsac_pkg::WORD_BITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sum_in,
    input  logic                          op_add,
    input  logic                          op_clear,
    output logic                          acc_out,
    output logic                          minor_start,
    output logic [edsac_pkg::POS_BITS-1:0] bit_pos,
    output logic                          busy,
    output logic                          done,
    output logic [WORD_BITS-1:0]          acc_word
);
    import edsac_pkg::*;

    logic last_bit;

    acc_mode_e            state_q, state_d;
    logic                 pend_valid_q, pend_valid_d;
    acc_mode_e            pend_mode_q, pend_mode_d;
    logic [WORD_BITS-1:0] tank_q, tank_d;
    logic [WORD_BITS-1:0] acc_word_q, acc_word_d;

    logic                 merged_valid;
    acc_mode_e            merged_mode;
    logic                 write_bit;

    minor_cycle_timer #(
        .WORD_BITS (WORD_BITS)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_pos     (bit_pos),
        .minor_start (minor_start),
        .last_bit    (last_bit)
    );

    // Fold this cycle's request into the pending slot; a clear, once
    // seen, cannot be displaced by a later add before the boundary.
    always_comb begin
        merged_valid = pend_valid_q | op_add | op_clear;
        merged_mode  = pend_mode_q;
        if (op_clear) begin
            merged_mode = CLEAR;
        end else if (op_add && !(pend_valid_q && pend_mode_q == CLEAR)) begin
            merged_mode = ADD;
        end
    end

    // Mode and pending-slot next state; the mode only moves on the wrap
    // edge, which also consumes the pending request (including one
    // arriving on the very last bit-time).
    always_comb begin
        state_d      = state_q;
        pend_valid_d = merged_valid;
        pend_mode_d  = merged_valid ? merged_mode : HOLD;
        if (last_bit) begin
            state_d      = merged_valid ? merged_mode : HOLD;
            pend_valid_d = 1'b0;
            pend_mode_d  = HOLD;
        end
    end

    // Select the bit shifted into the tank MSB; sum_in stays combinational
    // so the adder loop closes within one bit-time.
    always_comb begin
        write_bit = tank_q[0];
        case (state_q)
            HOLD:    write_bit = tank_q[0];
            ADD:     write_bit = sum_in;
            CLEAR:   write_bit = 1'b0;
            default: write_bit = tank_q[0];
        endcase
        tank_d     = {write_bit, tank_q[WORD_BITS-1:1]};
        acc_word_d = last_bit ? tank_d : acc_word_q;
    end

    // Tank, snapshot, mode and pending registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HOLD;
            pend_valid_q <= 1'b0;
            pend_mode_q  <= HOLD;
            tank_q       <= '0;
            acc_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_mode_q  <= pend_mode_d;
            tank_q       <= tank_d;
            acc_word_q   <= acc_word_d;
        end
    end

    assign acc_out  = tank_q[0];
    assign acc_word = acc_word_q;
    assign done     = last_bit && (state_q != HOLD);
    assign busy     = (state_q != HOLD) || pend_valid_q;

endmodule

// File: tb/tb_serial_accumulator.sv
// Self-checking bench for serial_accumulator with a serial adder in the loop.
module tb_serial_accumulator;

    localparam int W    = 18;
    localparam int MASK = (1 << W) - 1;

    localparam byte M_HOLD = 0;
    localparam byte M_ADD  = 1;
    localparam byte M_CLR  = 2;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         op_add   = 1'b0;
    logic         op_clear = 1'b0;
    logic         sum_in;
    logic         acc_out;
    logic         minor_start;
    logic [4:0]   bit_pos;
    logic         busy;
    logic         done;
    logic [W-1:0] acc_word;

    always #5 clk = ~clk;

    serial_accumulator #(.WORD_BITS(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sum_in      (sum_in),
        .op_add      (op_add),
        .op_clear    (op_clear),
        .acc_out     (acc_out),
        .minor_start (minor_start),
        .bit_pos     (bit_pos),
        .busy        (busy),
        .done        (done),
        .acc_word    (acc_word)
    );

    // Serial adder: tank bit + external operand bit + carry, carry cleared each word.
    logic [W-1:0] operand = '0;
    int           adder_pos;
    logic         carry_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adder_pos <= 0;
            carry_q   <= 1'b0;
        end else if (adder_pos == W - 1) begin
            adder_pos <= 0;
            carry_q   <= 1'b0;
        end else begin
            adder_pos <= adder_pos + 1;
            carry_q   <= (acc_out & operand[adder_pos]) | (acc_out & carry_q) |
                         (operand[adder_pos] & carry_q);
        end
    end

    assign sum_in = acc_out ^ operand[adder_pos] ^ carry_q;

    // Word-level reference model.
    int  m_pos;
    int  m_word;   // tank word as it stood at the start of this minor cycle
    int  m_accw;
    byte m_mode;
    byte m_pend;
    int  cyc;
    int  done_q[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic model_reset();
        m_pos  = 0;
        m_word = 0;
        m_accw = 0;
        m_mode = M_HOLD;
        m_pend = M_HOLD;
    endtask

    // One bit-time: drive requests, check outputs against the model, clock, update model.
    task automatic tick(input logic a, input logic c);
        logic exp_bit;
        logic exp_done;
        logic exp_busy;
        op_add   = a;
        op_clear = c;
        #1;
        exp_bit  = ((m_word >> m_pos) & 1) != 0;
        exp_done = (m_mode != M_HOLD) && (m_pos == W - 1);
        exp_busy = (m_mode != M_HOLD) || (m_pend != M_HOLD);
        n_total++;
        if (bit_pos !== m_pos[4:0]) $display("FAIL bit_pos cyc=%0d got %0d want %0d", cyc, bit_pos, m_pos);
        else n_pass++;
        n_total++;
        if (acc_out !== exp_bit) $display("FAIL acc_out cyc=%0d got %b want %b", cyc, acc_out, exp_bit);
        else n_pass++;
        n_total++;
        if (minor_start !== (m_pos == 0)) $display("FAIL minor_start cyc=%0d got %b want %b", cyc, minor_start, m_pos == 0);
        else n_pass++;
        n_total++;
        if (done !== exp_done) $display("FAIL done cyc=%0d got %b want %b", cyc, done, exp_done);
        else n_pass++;
        n_total++;
        if (busy !== exp_busy) $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, exp_busy);
        else n_pass++;
        n_total++;
        if (acc_word !== m_accw[W-1:0]) $display("FAIL acc_word cyc=%0d got %h want %h", cyc, acc_word, m_accw);
        else n_pass++;
        if (done === 1'b1) done_q.push_back(cyc);
        @(posedge clk);
        if (c) m_pend = M_CLR;
        else if (a && m_pend != M_CLR) m_pend = M_ADD;
        if (m_pos == W - 1) begin
            if (m_mode == M_ADD) m_word = (m_word + int'(operand)) & MASK;
            else if (m_mode == M_CLR) m_word = 0;
            m_accw = m_word;
            m_mode = m_pend;
            m_pend = M_HOLD;
            m_pos  = 0;
        end else begin
            m_pos++;
        end
        cyc++;
        @(negedge clk);
        op_add   = 1'b0;
        op_clear = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < W && m_pos != pos; i++) tick(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        op_add   = 1'b0;
        op_clear = 1'b0;
        operand  = '0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        done_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_total++;
        if ({acc_out, done, busy, minor_start} !== 4'b0001 || bit_pos !== 5'd0 || acc_word !== '0)
            $display("FAIL reset_state got out=%b done=%b busy=%b ms=%b pos=%0d word=%h want 0,0,0,1,0,0",
                     acc_out, done, busy, minor_start, bit_pos, acc_word);
        else n_pass++;
        do_reset();
        run(2 * W);
        n_total++;
        if (done_q.size() != 0) $display("FAIL idle_done got %0d pulses want 0", done_q.size());
        else n_pass++;
        $display("test_reset: 36 idle cycles, acc_word=%h", acc_word);
    endtask

    task automatic test_add_hold();
        do_reset();
        operand = 18'd5;
        run_to(3);
        tick(1'b1, 1'b0);
        run_to(0);
        run(W);
        n_total++;
        if (acc_word !== 18'd5) $display("FAIL add5_word got %h want 00005", acc_word);
        else n_pass++;
        run(3 * W);
        n_total++;
        if (acc_word !== 18'd5 || done_q.size() != 1)
            $display("FAIL add5_hold got word=%h dones=%0d want 00005, 1", acc_word, done_q.size());
        else n_pass++;
        $display("test_add_hold: add 5 then 3 hold cycles, acc_word=%h", acc_word);
    endtask

    task automatic test_overflow();
        do_reset();
        operand = 18'h3FFFF;
        tick(1'b1, 1'b0);
        run_to(0);
        run(W);
        n_total++;
        if (acc_word !== 18'h3FFFF) $display("FAIL ovf_load got %h want 3ffff", acc_word);
        else n_pass++;
        operand = 18'd1;
        done_q.delete();
        tick(1'b1, 1'b0);
        run_to(0);
        run(W);
        n_total++;
        if (acc_word !== '0 || done_q.size() != 1)
            $display("FAIL ovf_wrap got word=%h dones=%0d want 00000, 1", acc_word, done_q.size());
        else n_pass++;
        $display("test_overflow: 3ffff + 1 -> %h", acc_word);
    endtask

    task automatic test_clear_wins();
        bit busy_all;
        do_reset();
        operand = 18'd7;
        tick(1'b1, 1'b0);
        run_to(0);
        run(W);
        n_total++;
        if (acc_word !== 18'd7) $display("FAIL clr_setup got %h want 00007", acc_word);
        else n_pass++;
        run(5);
        done_q.delete();
        tick(1'b1, 1'b1);
        busy_all = 1'b1;
        for (int i = 0; i < (W - 6) + W; i++) begin
            #1;
            if (busy !== 1'b1) busy_all = 1'b0;
            tick(1'b0, 1'b0);
        end
        n_total++;
        if (acc_word !== '0 || done_q.size() != 1 || !busy_all)
            $display("FAIL clr_wins got word=%h dones=%0d busy_all=%b want 00000, 1, 1",
                     acc_word, done_q.size(), busy_all);
        else n_pass++;
        $display("test_clear_wins: add+clear on tank 7 -> %h", acc_word);
    endtask

    task automatic test_back_to_back();
        int op_val;
        do_reset();
        op_val  = int'($urandom_range(0, MASK));
        operand = op_val[W-1:0];
        tick(1'b1, 1'b0);
        run_to(0);
        run(W - 1);
        tick(1'b1, 1'b0);
        run(W);
        n_total++;
        if (done_q.size() != 2) $display("FAIL b2b_count got %0d want 2", done_q.size());
        else begin
            if (done_q[1] - done_q[0] != W)
                $display("FAIL b2b_spacing got %0d want %0d", done_q[1] - done_q[0], W);
            else n_pass++;
        end
        n_total++;
        if (acc_word !== 18'((2 * op_val) & MASK))
            $display("FAIL b2b_word got %h want %h", acc_word, (2 * op_val) & MASK);
        else n_pass++;
        $display("test_back_to_back: operand=%h, acc_word=%h", operand, acc_word);
    endtask

    task automatic test_reset_mid();
        do_reset();
        operand = 18'd9;
        tick(1'b1, 1'b0);
        run_to(0);
        run(W);
        n_total++;
        if (acc_word !== 18'd9) $display("FAIL mid_setup got %h want 00009", acc_word);
        else n_pass++;
        tick(1'b1, 1'b0);
        run_to(0);
        run(7);
        done_q.delete();
        rst_n = 1'b0;
        #1;
        n_total++;
        if (acc_out !== 1'b0 || acc_word !== '0 || bit_pos !== 5'd0 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_reset got out=%b word=%h pos=%0d done=%b busy=%b want 0,0,0,0,0",
                     acc_out, acc_word, bit_pos, done, busy);
        else n_pass++;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        run(W);
        n_total++;
        if (done_q.size() != 0) $display("FAIL mid_done got %0d pulses want 0", done_q.size());
        else n_pass++;
        $display("test_reset_mid: reset at bit 7 of add, acc_word=%h", acc_word);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 30 * W; i++) begin
            if (m_pos == 0 && $urandom_range(0, 1) == 1) operand = 18'($urandom_range(0, MASK));
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
        end
        run_to(0);
        n_total++;
        if (acc_word !== m_accw[W-1:0]) $display("FAIL rand_final got %h want %h", acc_word, m_accw);
        else n_pass++;
        $display("test_random: %0d done pulses, final acc_word=%h", done_q.size(), acc_word);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        cyc = 0;
        @(negedge clk);
        test_reset();
        test_add_hold();
        test_overflow();
        test_clear_wins();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
